// File: rtl/sp_ram_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter.
// Holds the FSM state encoding and the default parameter values
// used by the interface and the arbiter top.
package sp_ram_arb_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  // Ownership state: IDLE, or which port currently holds the RAM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Client-side bus of the RAM arbiter: both clients' request/address/data
// lines plus the grant and tagged read-return lines.
// Modports:
//   master - the clients: drive req/we/addr/wdata, receive gnt/rvalid/rdata
//   slave  - the arbiter: the reverse direction
interface sp_ram_arbiter_if
  import sp_ram_arb_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  req0;
  logic                  we0;
  logic [N-1:0]          addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1;
  logic                  we1;
  logic [N-1:0]          addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

endinterface

// File: rtl/sp_ram_arbiter_rr_pick2.sv
// Two-way round-robin pick.
// Ports:
//   req0, req1 - requests
//   last       - index of the port granted most recently
//   sel        - one-hot select, sel[0] = port 0, sel[1] = port 1, 0 if idle
// Under contention the port that was NOT granted last wins.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] sel
);

  // Round-robin choice between the two requesters.
  always_comb begin
    sel = 2'b00;
    if (req0 && req1) begin
      sel = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      sel = 2'b01;
    end else if (req1) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter with bounded burst ownership in front of a
// single-port RAM (1-cycle read latency).
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   bus      - client bus (slave modport): req/we/addr/wdata in, gnt/rvalid/rdata out
//   ram_we   - RAM write enable
//   ram_addr - RAM address
//   ram_din  - RAM write data
//   ram_dout - RAM read data (valid the cycle after the read is issued)
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_ram_arbiter_if.slave       bus,
  output logic                  ram_we,
  output logic [N-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int            CW    = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_e        state_r, state_nxt_s;
  logic          last_r, last_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          cont0_s, cont1_s;
  logic [1:0]    pick_s;
  logic          gnt0_s, gnt1_s;
  logic          rvalid0_r, rvalid1_r;

  // The owner keeps the RAM while under its burst budget, or indefinitely
  // while the other port is not asking for it.
  assign cont0_s = (state_r == OWN0) && bus.req0 && ((cnt_r < MAX_C) || !bus.req1);
  assign cont1_s = (state_r == OWN1) && bus.req1 && ((cnt_r < MAX_C) || !bus.req0);

  rr_pick2 u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .last (last_r),
    .sel  (pick_s)
  );

  // State register: ownership state, last-granted port and burst counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state: continue the burst, hand over to the round-robin pick, or go idle.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    cnt_nxt_s   = cnt_r;
    if (cont0_s || cont1_s) begin
      // At the budget only an uncontested owner gets here; restart its count.
      cnt_nxt_s = (cnt_r >= MAX_C) ? ONE_C : cnt_r + ONE_C;
    end else if (pick_s[0]) begin
      state_nxt_s = OWN0;
      last_nxt_s  = 1'b0;
      cnt_nxt_s   = ONE_C;
    end else if (pick_s[1]) begin
      state_nxt_s = OWN1;
      last_nxt_s  = 1'b1;
      cnt_nxt_s   = ONE_C;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Output: grants follow the same priority as the next-state decision;
  // nothing is granted while reset is asserted.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (cont0_s) begin
      gnt0_s = 1'b1;
    end else if (cont1_s) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = pick_s[0];
      gnt1_s = pick_s[1];
    end
  end

  // RAM port mux: the granted client drives the RAM, otherwise all zero.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0_s) begin
      ram_we   = bus.we0;
      ram_addr = bus.addr0;
      ram_din  = bus.wdata0;
    end else if (gnt1_s) begin
      ram_we   = bus.we1;
      ram_addr = bus.addr1;
      ram_din  = bus.wdata1;
    end else begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
    end
  end

  // Read-return tag pipeline, aligned with the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      rvalid0_r <= gnt0_s & ~bus.we0;
      rvalid1_r <= gnt1_s & ~bus.we1;
    end
  end

  assign bus.gnt0    = gnt0_s;
  assign bus.gnt1    = gnt1_s;
  assign bus.rvalid0 = rvalid0_r;
  assign bus.rvalid1 = rvalid1_r;
  assign bus.rdata0  = ram_dout;
  assign bus.rdata1  = ram_dout;

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-requester round-robin arbiter with bounded burst ownership in front of the team's `single_port_ram`. It multiplexes address, write-enable and write-data from two clients onto the RAM's single port and returns read data tagged to the issuing client. It sits between the RAM and its two masters.

## Interface
- `N`, 4, address width; RAM depth is 2^N.
- `DATA_WIDTH`, 8, data width.
- `MAX_BURST`, 4, maximum consecutive grants to one port while the other is requesting; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req0` / `req1`  in  1  access request from client k, held until granted.
- `we0` / `we1`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr0` / `addr1`  in  N  access address.
- `wdata0` / `wdata1`  in  DATA_WIDTH  write data.
- `gnt0` / `gnt1`  out  1  access accepted this cycle; combinational from state and requests.
- `rvalid0` / `rvalid1`  out  1  registered; `rdata` is valid for client k this cycle.
- `rdata0` / `rdata1`  out  DATA_WIDTH  both driven from `ram_dout`; meaningful only with `rvalid`.
- `ram_we`  out  1  to RAM `we`.
- `ram_addr`  out  N  to RAM `addr`.
- `ram_din`  out  DATA_WIDTH  to RAM `data_in`.
- `ram_dout`  in  DATA_WIDTH  from RAM `data_out`.

## Operation
- RAM contract:
  - Write commits on the edge where `ram_we`=1.
  - A read issued in cycle T appears on `ram_dout` in cycle T+1.
- FSM states:
  - IDLE
  - OWN0
  - OWN1
- Registers:
  - state
  - `last` (last granted port)
  - burst counter `cnt`, width clog2(MAX_BURST)+1
- Grant decision, evaluated each cycle in this order:
  1. **Continue ownership.** In OWNk with `req_k`=1, and either `cnt` < MAX_BURST or the other port is idle: grant k.
     - `cnt` increments.
     - If `cnt` = MAX_BURST and the other port is idle, `cnt` restarts at 1.
  2. **Switch ownership.** Otherwise, if any request is present, grant the requester that differs from `last`, or the only requester.
     - Next state is OWNj, `cnt` = 1, `last` = j.
  3. **No request.** Otherwise no grant; next state is IDLE. `last` is retained.
- At most one `gnt` is high per cycle. `gnt_k` implies `req_k`.
- Mux:
  - Granted port's `addr`, `wdata` and `we` drive the RAM.
  - With no grant: `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- Read return: `rvalid_k` is the registered value of (`gnt_k` & ~`we_k`). Writes produce no `rvalid`.
- Reset (`rst`=0 at an edge):
  - state = IDLE, `last` = 1, so port 0 wins the first contest.
  - `cnt` = 0, `rvalid0`/`rvalid1` = 0.
  - While `rst`=0: `gnt0`/`gnt1` = 0 and `ram_we` = 0, regardless of requests.

## Timing
- Grant latency: 0 cycles. A request seen in cycle T is granted in T if selected; a write lands at the end of T.
- Read latency: `rvalid_k` and `rdata_k` are high/valid in cycle T+1 for a read granted in T. Full throughput: one access per cycle.
- Write to address A in T, read of A granted in T+1: returns the new data in T+2.
- Back-to-back reads by different ports in T and T+1: `rvalid0` in T+1, `rvalid1` in T+2, no overlap.
- Reset mid-operation: a read granted in the cycle `rst` is sampled low produces no `rvalid`. The first grant is possible in the first cycle with `rst`=1.
- A requester dropping `req` while owner releases ownership the same cycle. The other port may be granted in that cycle.
- MAX_BURST=1 degenerates to strict alternation under contention.

## Structure
- Shared package `sp_ram_arb_pkg` holds:
  - state encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2)
  - default widths
- Sub-module `rr_pick2`: combinational two-way round-robin pick from (`req0`, `req1`, `last`), returning a one-hot select.
- The FSM, counter, mux and `rvalid` pipeline live in `sp_ram_arbiter`.

## Test plan
- **Reset priority:** reset, release, then `req0`=`req1`=1 reads from addr 3 and addr 5 -> `gnt0` first; `gnt1` the following cycle only after port 0 has dropped `req0`.
- **Burst limit:** MAX_BURST=4, both hold reads continuously -> grant pattern 0,0,0,0,1,1,1,1,0… and `rvalid` follows each grant by exactly one cycle.
- **Write/read data:** port 0 writes 8'hA5 to addr 7, port 1 reads addr 7 next cycle -> `rvalid1` with `rdata1`=8'hA5 two cycles after the write grant.
- **Solo requester:** only port 1 requests for 10 cycles -> granted every cycle; `cnt` wraps and there are no bubbles.
- **Reset mid-read:** `rst` driven low in the cycle of a granted read -> `rvalid` stays 0, `gnt` and `ram_we` are 0 during reset, and the next contest goes to port 0.
- **Idle outputs:** no requests -> `ram_we`=0, `ram_addr`=0, no `gnt` or `rvalid`.
